// File: rtl/rat_io_ports.sv
// rat_io_ports: RAT MCU peripheral I/O stage.
// Holds the LED and 7-seg output registers and the read mux for IN_PORT.
// Synchronizes the switches, and debounces the button into a latched INT
// request that software clears by writing port 0xF0.
// Optional feature macro: RAT_IO_PRESS_CNT_EN adds an 8-bit accepted-press
// counter, readable at port 0x23. When it is undefined, that port reads 0x00.
module rat_io_ports #(
    parameter int unsigned DB_COUNT = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    input  logic [7:0] SWITCHES,
    input  logic       BTN,
    output logic [7:0] IN_PORT,
    output logic [7:0] LEDS,
    output logic [7:0] SSEG_VAL,
    output logic       INT
);

    localparam logic [7:0] ID_LEDS = 8'h40;
    localparam logic [7:0] ID_SSEG = 8'h81;
    localparam logic [7:0] ID_ACK  = 8'hF0;
    localparam logic [7:0] ID_SW   = 8'h20;
    localparam logic [7:0] ID_BTN  = 8'h21;
    localparam logic [7:0] ID_INT  = 8'h22;
`ifdef RAT_IO_PRESS_CNT_EN
    localparam logic [7:0] ID_CNT  = 8'h23;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        PRESSED = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    logic [7:0]       r_sw_m;
    logic [7:0]       r_sw_s;
    logic             r_btn_m;
    logic             r_btn_s;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_btn_db;
    logic             w_ack;
    logic [7:0]       r_leds;
    logic [7:0]       r_sseg;
    logic             r_int;
`ifdef RAT_IO_PRESS_CNT_EN
    logic [7:0]       r_press_cnt;
`endif

    // Two-flop synchronizers for the asynchronous switch and button inputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sw_m  <= 8'h00;
            r_sw_s  <= 8'h00;
            r_btn_m <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sw_m  <= SWITCHES;
            r_sw_s  <= r_sw_m;
            r_btn_m <= BTN;
            r_btn_s <= r_btn_m;
        end
    end

    // Debounce state and stability counter registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Debounce next-state: a level must hold DB_COUNT cycles to be accepted
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!r_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!r_btn_s) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                // A bounce back high resumes the press without a new event
                if (r_btn_s) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_btn_db = (r_state == PRESSED) || (r_state == WAIT_LO);
    assign w_ack    = IO_STRB && (PORT_ID == ID_ACK);

    // Output registers loaded by MCU port writes
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_leds <= 8'h00;
            r_sseg <= 8'h00;
        end else if (IO_STRB) begin
            if (PORT_ID == ID_LEDS) r_leds <= OUT_PORT;
            if (PORT_ID == ID_SSEG) r_sseg <= OUT_PORT;
        end
    end

    // Interrupt latch: an accepted press sets it and overrides a same-cycle ack
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_int <= 1'b0;
        end else if (w_accept) begin
            r_int <= 1'b1;
        end else if (w_ack) begin
            r_int <= 1'b0;
        end
    end

`ifdef RAT_IO_PRESS_CNT_EN
    // Accepted-press counter, wraps naturally at 8 bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_press_cnt <= 8'h00;
        end else if (w_accept) begin
            r_press_cnt <= r_press_cnt + 8'h01;
        end
    end
`endif

    // Read mux to the MCU, combinational from PORT_ID
    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID)
            ID_SW:  IN_PORT = r_sw_s;
            ID_BTN: IN_PORT = {7'b0, w_btn_db};
            ID_INT: IN_PORT = {7'b0, r_int};
`ifdef RAT_IO_PRESS_CNT_EN
            ID_CNT: IN_PORT = r_press_cnt;
`endif
            default: IN_PORT = 8'h00;
        endcase
    end

    assign LEDS     = r_leds;
    assign SSEG_VAL = r_sseg;
    assign INT      = r_int;

endmodule

// File: tb/tb_rat_io_ports.sv
// tb_rat_io_ports: scoreboard bench for rat_io_ports, run with DB_COUNT=4.
module tb_rat_io_ports;

    logic       CLK;
    logic       RESET;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] SWITCHES;
    logic       BTN;
    logic [7:0] IN_PORT;
    logic [7:0] LEDS;
    logic [7:0] SSEG_VAL;
    logic       INT;

    localparam int SEL_LEDS = 0;
    localparam int SEL_SSEG = 1;
    localparam int SEL_INT  = 2;
    localparam int SEL_IN   = 3;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;
    int   model_cnt;

    rat_io_ports #(.DB_COUNT(4), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .SWITCHES (SWITCHES),
        .BTN      (BTN),
        .IN_PORT  (IN_PORT),
        .LEDS     (LEDS),
        .SSEG_VAL (SSEG_VAL),
        .INT      (INT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string n, input int sel, input logic [7:0] e);
        exp_t x;
        x.name = n;
        x.sel  = sel;
        x.exp  = e;
        exp_q.push_back(x);
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_LEDS: return LEDS;
            SEL_SSEG: return SSEG_VAL;
            SEL_INT:  return {7'b0, INT};
            default:  return IN_PORT;
        endcase
    endfunction

    function automatic logic [7:0] exp_cnt();
`ifdef RAT_IO_PRESS_CNT_EN
        return 8'(model_cnt);
`else
        return 8'h00;
`endif
    endfunction

    task automatic wr(input logic [7:0] id, input logic [7:0] d, input logic strb);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = strb;
        tick();
        IO_STRB  = 1'b0;
    endtask

    // One full accepted press followed by a release back to IDLE
    task automatic do_press();
        BTN = 1'b1;
        repeat (7) tick();
        model_cnt++;
        BTN = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        exp_t e;
        logic [7:0] o;
        RESET = 1'b1; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
        SWITCHES = 8'h00; BTN = 1'b0; model_cnt = 0;
        #12;
        PORT_ID = 8'h23;
        #1;
        push("rst_leds", SEL_LEDS, 8'h00);
        push("rst_sseg", SEL_SSEG, 8'h00);
        push("rst_int",  SEL_INT,  8'h00);
        push("rst_cnt",  SEL_IN,   8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        tick();
        RESET = 1'b0;
        wr(8'h40, 8'h77, 1'b1);
        wr(8'h81, 8'h12, 1'b1);
        push("pre_leds", SEL_LEDS, 8'h77);
        push("pre_sseg", SEL_SSEG, 8'h12);
        // Asynchronous assertion mid-cycle: outputs must clear with no clock edge
        #3 RESET = 1'b1;
        PORT_ID = 8'h23;
        #1;
        exp_q.delete();
        push("async_leds", SEL_LEDS, 8'h00);
        push("async_sseg", SEL_SSEG, 8'h00);
        push("async_int",  SEL_INT,  8'h00);
        push("async_cnt",  SEL_IN,   8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_writes();
        exp_t e;
        logic [7:0] o;
        wr(8'h40, 8'hA5, 1'b1);
        push("wr_leds", SEL_LEDS, 8'hA5);
        push("wr_leds_sseg0", SEL_SSEG, 8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        wr(8'h81, 8'h3C, 1'b1);
        push("wr_sseg", SEL_SSEG, 8'h3C);
        wr(8'h41, 8'hFF, 1'b1);
        push("wr_other_leds", SEL_LEDS, 8'hA5);
        push("wr_other_sseg", SEL_SSEG, 8'h3C);
        wr(8'h40, 8'h11, 1'b0);
        push("wr_nostrb_leds", SEL_LEDS, 8'hA5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reads();
        exp_t e;
        logic [7:0] o;
        SWITCHES = 8'h5A;
        PORT_ID  = 8'h20;
        tick();
        tick();
        push("rd_sw", SEL_IN, 8'h5A);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        PORT_ID = 8'h99;
        #1;
        push("rd_unmapped", SEL_IN, 8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_debounce();
        exp_t e;
        logic [7:0] o;
        // Short bounce: high for three samples only
        BTN = 1'b1;
        repeat (3) tick();
        BTN = 1'b0;
        repeat (8) tick();
        PORT_ID = 8'h21;
        #1;
        push("bounce_int", SEL_INT, 8'h00);
        push("bounce_db",  SEL_IN,  8'h00);
        // Held press: INT rises on the 7th edge counting the first sample
        BTN = 1'b1;
        repeat (6) tick();
        push("hold_int_early", SEL_INT, 8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        tick();
        model_cnt++;
        push("hold_int", SEL_INT, 8'h01);
        push("hold_db",  SEL_IN,  8'h01);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        PORT_ID = 8'h23;
        #1;
        push("hold_cnt", SEL_IN, exp_cnt());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        BTN = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_ack_priority();
        exp_t e;
        logic [7:0] o;
        PORT_ID = 8'h22;
        #1;
        push("ack_pre_rd", SEL_IN, 8'h01);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        wr(8'hF0, 8'h5A, 1'b1);
        push("ack_clear", SEL_INT, 8'h00);
        BTN = 1'b1;
        repeat (6) tick();
        push("ack_pre_press", SEL_INT, 8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        // Ack strobe lands on the same edge as the accepted press
        wr(8'hF0, 8'h00, 1'b1);
        model_cnt++;
        PORT_ID = 8'h23;
        #1;
        push("ack_set_wins", SEL_INT, 8'h01);
        push("ack_set_cnt",  SEL_IN,  exp_cnt());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        BTN = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [7:0] o;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 255; i++) do_press();
        PORT_ID = 8'h23;
        #1;
        push("wrap_ff", SEL_IN, exp_cnt());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        do_press();
        push("wrap_00",  SEL_IN,  exp_cnt());
        push("wrap_int", SEL_INT, 8'h01);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_debounce();
        exp_t e;
        logic [7:0] o;
        wr(8'hF0, 8'h00, 1'b1);
        BTN = 1'b1;
        repeat (4) tick();
        #2 RESET = 1'b1;
        PORT_ID = 8'h23;
        #1;
        model_cnt = 0;
        push("rstdb_int", SEL_INT, 8'h00);
        push("rstdb_cnt", SEL_IN,  8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        tick();
        tick();
        #2 RESET = 1'b0;
        repeat (6) tick();
        push("requal_early", SEL_INT, 8'h00);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        tick();
        model_cnt++;
        push("requal_int", SEL_INT, 8'h01);
        push("requal_cnt", SEL_IN,  exp_cnt());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = observe(e.sel); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %02h expected %02h", e.name, o, e.exp);
            else n_pass++;
        end
        BTN = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_writes();
        test_reads();
        test_debounce();
        test_ack_priority();
        test_wrap();
        test_reset_debounce();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
